// File: rtl/golden_nonce_uart_reporter_pkg.sv
`default_nettype none
// ============================================================================
// Module : golden_nonce_uart_reporter_pkg
// Brief  : Shared types and constants for the golden-nonce UART reporter.
// Rev    : 1.0  initial release
// ============================================================================
package golden_nonce_uart_reporter_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BITS_PER_BYTE  = 8;
    localparam int NONCE_WIDTH    = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/golden_nonce_uart_reporter_nonce_fifo.sv
`default_nettype none
// ============================================================================
// Module : nonce_fifo
// Brief  : Synchronous FIFO; a push while full is accepted only alongside a pop.
// Rev    : 1.0  initial release
// ============================================================================
module nonce_fifo #(
    parameter int DEPTH_LOG2 = 2,
    parameter int WIDTH      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [WIDTH-1:0]      i_din,
    output logic [WIDTH-1:0]      o_dout,
    output logic                  o_full,
    output logic                  o_empty,
    output logic [DEPTH_LOG2:0]   o_level
);

    localparam int                  c_DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] c_FULL_LEVEL = (DEPTH_LOG2 + 1)'(c_DEPTH);

    logic [WIDTH-1:0]      r_mem [c_DEPTH];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign o_full    = (r_level == c_FULL_LEVEL);
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_dout    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage carries no reset; only pointers and level define its contents.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/golden_nonce_uart_reporter.sv
`default_nettype none
// ============================================================================
// Module : golden_nonce_uart_reporter
// Brief  : Buffers golden nonces and sends each as four UART 8N1 bytes, MSB byte first.
// Rev    : 1.0  initial release
// ============================================================================
module golden_nonce_uart_reporter
    import golden_nonce_uart_reporter_pkg::*;
#(
    parameter int CLK_DIV         = 434,
    parameter int FIFO_DEPTH_LOG2 = 2
) (
    input  logic                       hash_clk,
    input  logic                       reset,
    input  logic                       nonce_valid,
    input  logic [NONCE_WIDTH-1:0]     golden_nonce,
    output logic                       uart_tx,
    output logic                       busy,
    output logic                       overflow,
    output logic [FIFO_DEPTH_LOG2:0]   fifo_level
);

    localparam logic [15:0] c_BAUD_LAST = 16'(CLK_DIV - 1);
    localparam logic [1:0]  c_LAST_BYTE = 2'(BYTES_PER_WORD - 1);
    localparam logic [2:0]  c_LAST_BIT  = 3'(BITS_PER_BYTE - 1);

    tx_state_t              r_state;
    logic [15:0]            r_baud;
    logic [1:0]             r_byte_idx;
    logic [2:0]             r_bit_idx;
    logic [NONCE_WIDTH-1:0] r_shift;
    logic                   r_tx;
    logic                   r_overflow;

    logic [NONCE_WIDTH-1:0]   w_dout;
    logic                     w_full;
    logic                     w_empty;
    logic                     w_baud_wrap;
    logic                     w_pop;
    logic                     w_push;
    logic                     w_drop;
    logic [BITS_PER_BYTE-1:0] w_cur_byte;
    logic [2:0]               w_next_bit_idx;

    assign w_baud_wrap    = (r_baud == c_BAUD_LAST);
    // Fetch in IDLE, or at the very end of the last stop bit to keep words contiguous.
    assign w_pop          = !w_empty &&
                            ((r_state == IDLE) ||
                             (r_state == STOP && w_baud_wrap && r_byte_idx == c_LAST_BYTE));
    assign w_push         = nonce_valid && (!w_full || w_pop);
    assign w_drop         = nonce_valid && w_full && !w_pop;
    assign w_cur_byte     = r_shift[NONCE_WIDTH-1 -: BITS_PER_BYTE];
    assign w_next_bit_idx = r_bit_idx + 3'd1;

    assign uart_tx  = r_tx;
    assign busy     = (r_state != IDLE);
    assign overflow = r_overflow;

    nonce_fifo #(
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2),
        .WIDTH      (NONCE_WIDTH)
    ) u_nonce_fifo (
        .clk     (hash_clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (golden_nonce),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    always_ff @(posedge hash_clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_baud     <= '0;
            r_byte_idx <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_overflow <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            case (r_state)
                IDLE: begin
                    r_baud <= '0;
                    if (w_pop) begin
                        r_shift    <= w_dout;
                        r_byte_idx <= '0;
                        r_tx       <= 1'b0;
                        r_state    <= START;
                    end
                end
                START: begin
                    if (w_baud_wrap) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= w_cur_byte[0];
                        r_state   <= DATA;
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                DATA: begin
                    if (w_baud_wrap) begin
                        r_baud <= '0;
                        if (r_bit_idx == c_LAST_BIT) begin
                            r_tx    <= 1'b1;
                            r_state <= STOP;
                        end else begin
                            r_bit_idx <= w_next_bit_idx;
                            r_tx      <= w_cur_byte[w_next_bit_idx];
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                STOP: begin
                    if (w_baud_wrap) begin
                        r_baud <= '0;
                        if (r_byte_idx != c_LAST_BYTE) begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                            r_shift    <= r_shift << BITS_PER_BYTE;
                            r_tx       <= 1'b0;
                            r_state    <= START;
                        end else if (w_pop) begin
                            r_shift    <= w_dout;
                            r_byte_idx <= '0;
                            r_tx       <= 1'b0;
                            r_state    <= START;
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_golden_nonce_uart_reporter.sv
`default_nettype none
// ============================================================================
// Module : tb_golden_nonce_uart_reporter
// Brief  : Scoreboard bench: a line decoder rebuilds words and checks them in order.
// Rev    : 1.0  initial release
// ============================================================================
module tb_golden_nonce_uart_reporter;

    localparam int CLK_DIV         = 4;
    localparam int FIFO_DEPTH_LOG2 = 2;

    logic        hash_clk = 1'b0;
    logic        reset;
    logic        nonce_valid;
    logic [31:0] golden_nonce;
    logic        uart_tx;
    logic        busy;
    logic        overflow;
    logic [FIFO_DEPTH_LOG2:0] fifo_level;

    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    int          m_active = 0;
    int          m_cnt = 0;
    int          m_byte_n = 0;
    int          m_starts = 0;
    logic [7:0]  m_byte = '0;
    logic [31:0] m_word = '0;
    int          busy_cycles = 0;

    golden_nonce_uart_reporter #(
        .CLK_DIV         (CLK_DIV),
        .FIFO_DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) dut (
        .hash_clk     (hash_clk),
        .reset        (reset),
        .nonce_valid  (nonce_valid),
        .golden_nonce (golden_nonce),
        .uart_tx      (uart_tx),
        .busy         (busy),
        .overflow     (overflow),
        .fifo_level   (fifo_level)
    );

    always #5 hash_clk = ~hash_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge hash_clk);
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy !== 1'b0 && n < 5000) begin
            step();
            n++;
        end
        chk("idle_timeout", (n >= 5000) ? 32'd1 : 32'd0, 32'd0);
        repeat (5) step();
        chk("queue_drained", exp_q.size(), 0);
    endtask

    // Line decoder: samples mid-bit on the falling clock edge, aborts on reset.
    always @(negedge hash_clk) begin
        if (busy === 1'b1) busy_cycles++;
        if (reset === 1'b1) begin
            m_active = 0;
            m_byte_n = 0;
        end else if (m_active == 0) begin
            if (uart_tx === 1'b0) begin
                m_active = 1;
                m_cnt    = 0;
                m_starts++;
            end
        end else begin
            m_cnt++;
            if (m_cnt == CLK_DIV / 2) begin
                chk("start_bit", {31'd0, uart_tx}, 32'd0);
            end else if (m_cnt == 9 * CLK_DIV + CLK_DIV / 2) begin
                chk("stop_bit", {31'd0, uart_tx}, 32'd1);
                m_word = {m_word[23:0], m_byte};
                m_byte_n++;
                m_active = 0;
                if (m_byte_n == 4) begin
                    m_byte_n = 0;
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL word_unexpected: got %08h expected none", m_word);
                    end else begin
                        chk("word", m_word, exp_q.pop_front());
                    end
                end
            end else if (m_cnt > CLK_DIV / 2 && ((m_cnt - CLK_DIV / 2) % CLK_DIV) == 0) begin
                m_byte = {uart_tx, m_byte[7:1]};
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] words4 [6];
        logic [31:0] words6 [6];
        int starts0;
        int n_low;

        words4[0] = 32'h1111_0001; words4[1] = 32'h2222_0002; words4[2] = 32'h3333_0003;
        words4[3] = 32'h4444_0004; words4[4] = 32'h5555_0005; words4[5] = 32'h6666_0006;
        words6[0] = 32'hC0DE_0000; words6[1] = 32'hC0DE_0101; words6[2] = 32'hC0DE_0202;
        words6[3] = 32'hC0DE_0303; words6[4] = 32'hC0DE_0404; words6[5] = 32'hBEEF_F00D;

        reset = 1'b1;
        nonce_valid = 1'b0;
        golden_nonce = '0;

        // Reset held for five cycles, then released.
        for (int i = 0; i < 8; i++) begin
            if (i == 5) reset = 1'b0;
            step();
            chk("rst_tx", {31'd0, uart_tx}, 32'd1);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_ovf", {31'd0, overflow}, 32'd0);
            chk("rst_level", {29'd0, fifo_level}, 32'd0);
        end

        // Single word: latency and duration.
        repeat (2) step();
        busy_cycles = 0;
        nonce_valid = 1'b1;
        golden_nonce = 32'h1234_ABCD;
        exp_q.push_back(32'h1234_ABCD);
        step();
        nonce_valid = 1'b0;
        chk("t2_level_n1", {29'd0, fifo_level}, 32'd1);
        chk("t2_tx_n1", {31'd0, uart_tx}, 32'd1);
        step();
        chk("t2_tx_n2", {31'd0, uart_tx}, 32'd0);
        chk("t2_busy_n2", {31'd0, busy}, 32'd1);
        chk("t2_level_n2", {29'd0, fifo_level}, 32'd0);
        wait_idle();
        chk("t2_busy_cycles", busy_cycles, 160);

        // Three back-to-back strobes.
        busy_cycles = 0;
        nonce_valid = 1'b1;
        golden_nonce = 32'h0123_4567; exp_q.push_back(golden_nonce);
        step();
        chk("t3_level_a", {29'd0, fifo_level}, 32'd1);
        golden_nonce = 32'h89AB_CDEF; exp_q.push_back(golden_nonce);
        step();
        chk("t3_level_b", {29'd0, fifo_level}, 32'd1);
        golden_nonce = 32'hFEDC_BA98; exp_q.push_back(golden_nonce);
        step();
        chk("t3_level_c", {29'd0, fifo_level}, 32'd2);
        nonce_valid = 1'b0;
        wait_idle();
        chk("t3_busy_cycles", busy_cycles, 480);
        chk("t3_ovf", {31'd0, overflow}, 32'd0);

        // Six strobes into a four-deep FIFO: the sixth is dropped.
        busy_cycles = 0;
        for (int i = 0; i < 6; i++) begin
            nonce_valid = 1'b1;
            golden_nonce = words4[i];
            if (i < 5) exp_q.push_back(words4[i]);
            step();
            if (i == 4) chk("t4_ovf_before", {31'd0, overflow}, 32'd0);
        end
        nonce_valid = 1'b0;
        chk("t4_ovf_set", {31'd0, overflow}, 32'd1);
        chk("t4_level_peak", {29'd0, fifo_level}, 32'd4);
        wait_idle();
        chk("t4_ovf_sticky", {31'd0, overflow}, 32'd1);
        chk("t4_busy_cycles", busy_cycles, 800);

        // Reset in the data phase of byte 1 aborts everything.
        nonce_valid = 1'b1;
        golden_nonce = 32'h5A3C_F00F;
        step();
        golden_nonce = 32'h0F0F_A5A5;
        step();
        nonce_valid = 1'b0;
        repeat (50) step();
        chk("t5_busy_pre", {31'd0, busy}, 32'd1);
        chk("t5_level_pre", {29'd0, fifo_level}, 32'd1);
        reset = 1'b1;
        step();
        chk("t5_tx", {31'd0, uart_tx}, 32'd1);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_level", {29'd0, fifo_level}, 32'd0);
        chk("t5_ovf", {31'd0, overflow}, 32'd0);
        reset = 1'b0;
        starts0 = m_starts;
        n_low = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (uart_tx !== 1'b1) n_low++;
        end
        chk("t5_line_quiet", n_low, 0);
        chk("t5_no_frames", m_starts - starts0, 0);

        // Strobe into a full FIFO on the same edge as the word-boundary pop.
        busy_cycles = 0;
        for (int i = 0; i < 5; i++) begin
            nonce_valid = 1'b1;
            golden_nonce = words6[i];
            exp_q.push_back(words6[i]);
            step();
        end
        nonce_valid = 1'b0;
        chk("t6_level_full", {29'd0, fifo_level}, 32'd4);
        repeat (156) step();
        chk("t6_stop_bit", {31'd0, uart_tx}, 32'd1);
        chk("t6_level_pre", {29'd0, fifo_level}, 32'd4);
        nonce_valid = 1'b1;
        golden_nonce = words6[5];
        exp_q.push_back(words6[5]);
        step();
        nonce_valid = 1'b0;
        chk("t6_level_post", {29'd0, fifo_level}, 32'd4);
        chk("t6_ovf", {31'd0, overflow}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd1);
        wait_idle();
        chk("t6_busy_cycles", busy_cycles, 960);
        chk("t6_ovf_end", {31'd0, overflow}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
